// File: rtl/pausable_clock_sequencer_if.sv
// Control/status bundle between the CSR-side master and the pausable clock sequencer.
interface pausable_clock_sequencer_if #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int NUM_PAUSE_REQ      = 2
);
  logic                          clk_en_i;
  logic                          start_i;
  logic                          stop_i;
  logic [RATE_COUNTER_WIDTH-1:0] half_rate_i;
  logic                          starting_polarity_i;
  logic [NUM_PAUSE_REQ-1:0]      pause_req_i;
  logic [NUM_PAUSE_REQ-1:0]      pause_polarity_i;
  logic [NUM_PAUSE_REQ-1:0]      pause_grant_o;
  logic                          generation_en_o;
  logic                          init_o;
  logic                          starting_polarity_o;
  logic                          locked_o;
  logic                          quarter_toggle_event_o;
  logic                          half_toggle_event_o;
  logic                          pause_en_o;
  logic                          pause_polarity_o;
  logic                          busy_o;

  modport master (
    output clk_en_i, start_i, stop_i, half_rate_i, starting_polarity_i,
           pause_req_i, pause_polarity_i,
    input  pause_grant_o, generation_en_o, init_o, starting_polarity_o, locked_o,
           quarter_toggle_event_o, half_toggle_event_o, pause_en_o, pause_polarity_o,
           busy_o
  );

  modport slave (
    input  clk_en_i, start_i, stop_i, half_rate_i, starting_polarity_i,
           pause_req_i, pause_polarity_i,
    output pause_grant_o, generation_en_o, init_o, starting_polarity_o, locked_o,
           quarter_toggle_event_o, half_toggle_event_o, pause_en_o, pause_polarity_o,
           busy_o
  );
endinterface

// File: rtl/pausable_clock_sequencer.sv
// Start/rate/lock/stop sequencing and pause arbitration for one pausable_clock instance.
// Define CLKS_ALOT_PAUSE_ROUND_ROBIN_EN for round-robin pause arbitration (default: fixed priority).
module pausable_clock_sequencer #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int LOCK_CYCLES        = 4,
  parameter int NUM_PAUSE_REQ      = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  pausable_clock_sequencer_if.slave bus
);

  localparam int RCW = RATE_COUNTER_WIDTH;
  localparam int N   = NUM_PAUSE_REQ;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_LOCKED,
    S_DRAIN
  } state_t;

  state_t         state;
  logic [RCW-1:0] rate;
  logic [RCW-1:0] count;
  logic           phase;
  logic [7:0]     lock_cnt;
  logic           pol_q;
  logic           gen_en;
  logic           init_pulse;
  logic           locked;
  logic           quarter_evt;
  logic           half_evt;
  logic [N-1:0]   grant;
  logic           pause_en;
  logic           pause_pol;
  logic           busy;
  logic [N-1:0]   next_grant;
  logic [PW-1:0]  prio_base;

  // A rate below 2 cannot produce distinct quarter and half events.
  function automatic logic [RCW-1:0] clamp_rate(input logic [RCW-1:0] r);
    return (r < RCW'(2)) ? RCW'(2) : r;
  endfunction

  function automatic logic [N-1:0] pick_winner(input logic [N-1:0] req,
                                               input logic [PW-1:0] base);
    logic [N-1:0] g;
    logic         found;
    int           idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

`ifdef CLKS_ALOT_PAUSE_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;

  function automatic logic [PW-1:0] ptr_after(input logic [N-1:0] g);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k]) p = PW'((k + 1) % N);
    end
    return p;
  endfunction

  assign prio_base = rr_ptr;
`else
  assign prio_base = '0;
`endif

  // The current holder keeps its grant for as long as it keeps requesting.
  always_comb begin
    next_grant = grant;
    if (!(|(grant & bus.pause_req_i))) next_grant = pick_winner(bus.pause_req_i, prio_base);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      rate        <= '0;
      count       <= '0;
      phase       <= 1'b0;
      lock_cnt    <= '0;
      pol_q       <= 1'b0;
      gen_en      <= 1'b0;
      init_pulse  <= 1'b0;
      locked      <= 1'b0;
      quarter_evt <= 1'b0;
      half_evt    <= 1'b0;
      grant       <= '0;
      pause_en    <= 1'b0;
      pause_pol   <= 1'b0;
      busy        <= 1'b0;
`ifdef CLKS_ALOT_PAUSE_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else if (!bus.clk_en_i) begin
      init_pulse  <= 1'b0;
      quarter_evt <= 1'b0;
      half_evt    <= 1'b0;
    end else begin
      init_pulse  <= 1'b0;
      quarter_evt <= 1'b0;
      half_evt    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state      <= S_INIT;
            rate       <= clamp_rate(bus.half_rate_i);
            pol_q      <= bus.starting_polarity_i;
            init_pulse <= 1'b1;
            busy       <= 1'b1;
            lock_cnt   <= '0;
          end
        end
        S_INIT: begin
          state  <= S_RUN;
          gen_en <= 1'b1;
          count  <= rate - RCW'(1);
          phase  <= pol_q;
        end
        S_RUN, S_LOCKED, S_DRAIN: begin
          if (!gen_en) begin
            // Drain already parked the clock at its idle level.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (count == '0) begin
              count       <= rate - RCW'(1);
              half_evt    <= 1'b1;
              quarter_evt <= 1'b1;
              phase       <= ~phase;
              if (state == S_RUN) begin
                if (lock_cnt == 8'(LOCK_CYCLES - 1)) begin
                  state  <= S_LOCKED;
                  locked <= 1'b1;
                end else begin
                  lock_cnt <= lock_cnt + 8'd1;
                end
              end else if (state == S_LOCKED) begin
                grant     <= next_grant;
                pause_en  <= |next_grant;
                pause_pol <= |(next_grant & bus.pause_polarity_i);
`ifdef CLKS_ALOT_PAUSE_ROUND_ROBIN_EN
                if ((next_grant != grant) && (|next_grant)) rr_ptr <= ptr_after(next_grant);
`endif
              end else begin
                grant     <= '0;
                pause_en  <= 1'b0;
                pause_pol <= 1'b0;
                if (~phase == pol_q) gen_en <= 1'b0;
              end
            end else begin
              count <= count - RCW'(1);
              if (count == (rate >> 1)) quarter_evt <= 1'b1;
            end
            // Stop overrides any lock transition taken on the same edge.
            if (bus.stop_i && (state != S_DRAIN)) begin
              state  <= S_DRAIN;
              locked <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.generation_en_o        = gen_en;
  assign bus.init_o                 = init_pulse;
  assign bus.starting_polarity_o    = pol_q;
  assign bus.locked_o               = locked;
  assign bus.quarter_toggle_event_o = quarter_evt;
  assign bus.half_toggle_event_o    = half_evt;
  assign bus.pause_grant_o          = grant;
  assign bus.pause_en_o             = pause_en;
  assign bus.pause_polarity_o       = pause_pol;
  assign bus.busy_o                 = busy;

endmodule

// File: tb/tb_pausable_clock_sequencer.sv
// Randomized and directed bench for pausable_clock_sequencer against an event-level reference model.
module tb_pausable_clock_sequencer;

  localparam int RCW  = 16;
  localparam int LOCK = 4;
  localparam int NREQ = 2;

  localparam int M_IDLE   = 0;
  localparam int M_INIT   = 1;
  localparam int M_RUN    = 2;
  localparam int M_LOCKED = 3;
  localparam int M_DRAIN  = 4;

  logic clk;
  logic arst_n;

  logic            clk_en;
  logic            start;
  logic            stop;
  logic [RCW-1:0]  half_rate;
  logic            spol;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ppol_in;

  pausable_clock_sequencer_if #(.RATE_COUNTER_WIDTH(RCW), .NUM_PAUSE_REQ(NREQ)) bus ();

  assign bus.clk_en_i            = clk_en;
  assign bus.start_i             = start;
  assign bus.stop_i              = stop;
  assign bus.half_rate_i         = half_rate;
  assign bus.starting_polarity_i = spol;
  assign bus.pause_req_i         = req;
  assign bus.pause_polarity_i    = ppol_in;

  pausable_clock_sequencer #(
    .RATE_COUNTER_WIDTH(RCW),
    .LOCK_CYCLES       (LOCK),
    .NUM_PAUSE_REQ     (NREQ)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: position within the generated waveform is tracked as a plain
  // count of enabled cycles since generation began, and events follow from modulo arithmetic.
  int   m_mode;
  int   m_R;
  int   m_n;
  int   m_halves;
  int   m_holder;
  logic m_pol;
  logic e_gen, e_init, e_spol, e_locked, e_q, e_h, e_ppol, e_busy;

  int cyc;
  int h_last, h_gap, q_last, q_gap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_R      = 2;
    m_n      = 0;
    m_halves = 0;
    m_holder = -1;
    m_pol    = 1'b0;
    e_gen    = 1'b0;
    e_init   = 1'b0;
    e_spol   = 1'b0;
    e_locked = 1'b0;
    e_q      = 1'b0;
    e_h      = 1'b0;
    e_ppol   = 1'b0;
    e_busy   = 1'b0;
  endtask

  task automatic model_step();
    int mode0;
    int pos;
    bit half;
    e_init = 1'b0;
    e_q    = 1'b0;
    e_h    = 1'b0;
    if (!clk_en) return;
    mode0 = m_mode;
    if (mode0 == M_IDLE) begin
      if (start) begin
        m_mode = M_INIT;
        m_R    = (half_rate < 2) ? 2 : int'(half_rate);
        m_pol  = spol;
        e_spol = spol;
        e_init = 1'b1;
        e_busy = 1'b1;
      end
    end else if (mode0 == M_INIT) begin
      m_mode   = M_RUN;
      e_gen    = 1'b1;
      m_n      = 0;
      m_halves = 0;
    end else if (mode0 == M_DRAIN && !e_gen) begin
      m_mode = M_IDLE;
      e_busy = 1'b0;
    end else begin
      m_n++;
      pos  = m_n % m_R;
      half = (pos == 0);
      e_h  = half;
      e_q  = half || (pos == (m_R + 1) / 2);
      if (half) begin
        m_halves++;
        if (mode0 == M_RUN && m_halves == LOCK) begin
          m_mode   = M_LOCKED;
          e_locked = 1'b1;
        end else if (mode0 == M_LOCKED) begin
          if (!(m_holder >= 0 && req[m_holder])) begin
            m_holder = -1;
            for (int k = NREQ - 1; k >= 0; k--) if (req[k]) m_holder = k;
          end
          e_ppol = (m_holder >= 0) ? ppol_in[m_holder] : 1'b0;
        end else if (mode0 == M_DRAIN) begin
          m_holder = -1;
          e_ppol   = 1'b0;
          // An even number of half periods puts the clock back at its starting level.
          if (m_halves % 2 == 0) e_gen = 1'b0;
        end
      end
      if (stop && (mode0 == M_RUN || mode0 == M_LOCKED)) begin
        m_mode   = M_DRAIN;
        e_locked = 1'b0;
      end
    end
  endtask

  task automatic compare_outs();
    logic [NREQ-1:0] eg;
    eg = (m_holder >= 0) ? NREQ'(1 << m_holder) : '0;
    check_eq("gen",     32'(bus.generation_en_o),        32'(e_gen));
    check_eq("init",    32'(bus.init_o),                 32'(e_init));
    check_eq("spol",    32'(bus.starting_polarity_o),    32'(e_spol));
    check_eq("locked",  32'(bus.locked_o),               32'(e_locked));
    check_eq("quarter", 32'(bus.quarter_toggle_event_o), 32'(e_q));
    check_eq("half",    32'(bus.half_toggle_event_o),    32'(e_h));
    check_eq("grant",   32'(bus.pause_grant_o),          32'(eg));
    check_eq("pen",     32'(bus.pause_en_o),             32'(m_holder >= 0));
    check_eq("ppol",    32'(bus.pause_polarity_o),       32'(e_ppol));
    check_eq("busy",    32'(bus.busy_o),                 32'(e_busy));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_outs();
    if (bus.half_toggle_event_o) begin
      h_gap  = cyc - h_last;
      h_last = cyc;
    end
    if (bus.quarter_toggle_event_o) begin
      q_gap  = cyc - q_last;
      q_last = cyc;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {22'd0, bus.generation_en_o, bus.init_o, bus.starting_polarity_o,
                              bus.locked_o, bus.quarter_toggle_event_o, bus.half_toggle_event_o,
                              bus.pause_grant_o, bus.pause_en_o, bus.pause_polarity_o,
                              bus.busy_o}, 32'd0);
  endtask

  task automatic do_async_reset();
    #2 arst_n = 1'b0;
    #1;
    check_all_zero("arst");
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic wait_half(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      seen = bus.half_toggle_event_o;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_start(input logic [RCW-1:0] r, input logic p);
    half_rate = r;
    spol      = p;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  task automatic stop_and_drain();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (30) cycle();
    check_eq("drained_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    h_last    = 0;
    q_last    = 0;
    h_gap     = 0;
    q_gap     = 0;
    clk_en    = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    half_rate = '0;
    spol      = 1'b0;
    req       = '0;
    ppol_in   = '0;
    arst_n    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arst_n = 1'b1;

    // Rate 4, polarity 1: init pulse, 4-clk halves, 2-clk quarters, lock on 4th half event.
    run_start(16'd4, 1'b1);
    repeat (30) cycle();
    check_eq("s1_locked", 32'(bus.locked_o), 32'd1);
    check_eq("s1_hgap", 32'(h_gap), 32'd4);
    check_eq("s1_qgap", 32'(q_gap), 32'd2);

    // Contention: lowest index wins, then hands over when released.
    req     = 2'b11;
    ppol_in = 2'b10;
    wait_half("s4a");
    check_eq("s4_grant0", 32'(bus.pause_grant_o), 32'd1);
    req = 2'b10;
    wait_half("s4b");
    check_eq("s4_grant1", 32'(bus.pause_grant_o), 32'd2);
    check_eq("s4_ppol1", 32'(bus.pause_polarity_o), 32'd1);
    req = 2'b00;
    repeat (10) cycle();

    stop_and_drain();

    // Rates below 2 clamp to 2.
    run_start(16'd0, 1'b0);
    repeat (20) cycle();
    check_eq("s2_hgap0", 32'(h_gap), 32'd2);
    check_eq("s2_qgap0", 32'(q_gap), 32'd1);
    stop_and_drain();
    run_start(16'd1, 1'b1);
    repeat (20) cycle();
    check_eq("s2_hgap1", 32'(h_gap), 32'd2);
    check_eq("s2_qgap1", 32'(q_gap), 32'd1);
    stop_and_drain();

    // Clock-enable gap stretches the half period by exactly its length.
    run_start(16'd4, 1'b0);
    repeat (10) cycle();
    wait_half("s5a");
    cycle();
    clk_en = 1'b0;
    repeat (3) cycle();
    clk_en = 1'b1;
    wait_half("s5b");
    check_eq("s5_hgap", 32'(h_gap), 32'd7);
    stop_and_drain();

    // Asynchronous reset during drain, then a fresh start behaves normally.
    run_start(16'd6, 1'b1);
    repeat (40) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (2) cycle();
    do_async_reset();
    run_start(16'd4, 1'b1);
    repeat (30) cycle();
    check_eq("s6_locked", 32'(bus.locked_o), 32'd1);
    check_eq("s6_hgap", 32'(h_gap), 32'd4);
    stop_and_drain();

    for (int i = 0; i < 2500; i++) begin
      clk_en    = ($urandom_range(0, 9) != 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      half_rate = RCW'($urandom_range(0, 9));
      spol      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ppol_in = NREQ'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) do_async_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
